ex_stage_ctrl: RTL
==================

Name: ex_stage_ctrl

Overview:
Sequencing controller for the execute stage. It owns the valid/ready handshake between ID and EX and between EX and MEM. It issues single-cycle ALU operations directly and starts and waits for multi-cycle ALU operations (mul/div). It holds the EX result until MEM accepts it, supports pipeline flush, and guards multi-cycle operations with a timeout.

Parameters:
DATA_W, 64, width of ALU result and result register
TIMEOUT, 64, max cycles in BUSY before forced abort (≥2)
CNT_W, 32, width of stall performance counter

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
id_valid  input  1  ID presents a valid instruction
multi_cycle  input  1  qualifies id_valid: op needs multi-cycle ALU
ex_ready  output  1  EX can accept from ID this cycle
alu_result  input  DATA_W  ALU output (combinational for single-cycle ops)
alu_start  output  1  one-cycle start pulse to multi-cycle ALU
alu_done  input  1  multi-cycle ALU result valid (one-cycle pulse)
alu_cancel  output  1  one-cycle abort to multi-cycle ALU
ex_valid  output  1  result_q valid toward MEM
mem_ready  input  1  MEM accepts this cycle
result_q  output  DATA_W  registered EX result
flush  input  1  kill instruction in EX (branch/trap redirect)
timeout_err  output  1  sticky: a multi-cycle op timed out
stall_cnt  output  CNT_W  cycles with ex_valid=1 and mem_ready=0

Behaviour:
- Reset (reset=0, async): state=IDLE, result_q=0, timeout_err=0, stall_cnt=0, timer=0. Outputs: ex_valid=0, alu_start=0, alu_cancel=0, ex_ready=1 once reset releases.
- States: IDLE, BUSY, DONE. ex_valid = (state==DONE).
- ex_ready = !flush && (state==IDLE || (state==DONE && mem_ready)). This allows back-to-back acceptance while draining DONE.
- accept = id_valid && ex_ready.
- Accept with multi_cycle=0:
  - result_q <= alu_result.
  - Next state DONE; ex_valid=1 the next cycle (latency 1).
- Accept with multi_cycle=1:
  - alu_start=1 combinationally in the accept cycle only.
  - Next state BUSY; timer <= 0.
- BUSY:
  - Timer increments each cycle.
  - On alu_done: result_q <= alu_result, go DONE, timer cleared.
  - If timer reaches TIMEOUT-1 without alu_done: alu_cancel=1 that cycle, result_q <= 0, timeout_err <= 1, go DONE.
  - alu_done and the timeout in the same cycle: alu_done wins, no error.
- DONE:
  - If mem_ready and no new accept: go IDLE.
  - If mem_ready and accept: go to DONE or BUSY per the new op, as from IDLE.
  - Without mem_ready: hold; result_q stable.
- alu_done outside BUSY is ignored.
- flush (priority over everything except reset):
  - Next state IDLE; ex_valid=0 the next cycle.
  - If state==BUSY: alu_cancel=1 that cycle, timer cleared.
  - ex_ready=0 during the flush cycle, so no accept.
  - result_q retains its old value; it is don't-care.
  - A DONE result is discarded even if mem_ready=1 in the same cycle; MEM must also honor flush.
- alu_start and alu_cancel are never both 1 in a cycle.
- stall_cnt increments when ex_valid && !mem_ready. It saturates at all-ones. It is not cleared by flush.
- timeout_err is cleared only by reset.

Test Plan:
1. Single-cycle op: reset release, id_valid=1, multi_cycle=0, alu_result=0x1234 → next cycle ex_valid=1, result_q=0x1234; mem_ready=1 → IDLE next cycle, alu_start never asserted.
2. Back-to-back single-cycle: three consecutive accepts with mem_ready=1 and results 1, 2, 3 → ex_valid held 3 cycles with result_q=1, 2, 3; ex_ready=1 throughout.
3. Multi-cycle: accept with multi_cycle=1 → alu_start one cycle, ex_ready=0; alu_done after 5 cycles with alu_result=0xDEAD → next cycle ex_valid=1, result_q=0xDEAD, timeout_err=0.
4. Backpressure: DONE with mem_ready=0 for 4 cycles → result_q stable, ex_ready=0, stall_cnt=4; then mem_ready=1 → IDLE.
5. Flush: assert flush in the 2nd BUSY cycle → alu_cancel=1 that cycle, next cycle IDLE, ex_valid=0; a later alu_done is ignored. Flush in DONE with mem_ready=1 → ex_ready=0 that cycle, IDLE next.
6. Timeout and reset: TIMEOUT=8, no alu_done → alu_cancel at the 8th BUSY cycle, ex_valid=1 with result_q=0, timeout_err=1 sticky. Assert reset mid-BUSY → all outputs return to reset values immediately, without a clock edge.

Source files
------------

// File: rtl/ex_stage_ctrl.sv
// Execute-stage sequencer: owns the ID->EX and EX->MEM valid/ready handshakes,
// issues single-cycle ALU ops directly and supervises multi-cycle ops with a timeout.
module ex_stage_ctrl #(
   parameter int DATA_W  = 64,
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              id_valid,
   input  logic              multi_cycle,
   output logic              ex_ready,
   input  logic [DATA_W-1:0] alu_result,
   output logic              alu_start,
   input  logic              alu_done,
   output logic              alu_cancel,
   output logic              ex_valid,
   input  logic              mem_ready,
   output logic [DATA_W-1:0] result_q,
   input  logic              flush,
   output logic              timeout_err,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int              TW         = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0]   TIMER_ONE  = TW'(1);
   localparam logic [CNT_W-1:0] STALL_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e           state_q;
   logic [TW-1:0]    timer_q;
   logic             err_q;
   logic [CNT_W-1:0] stall_q;

   logic accept_s;
   logic busy_s;
   logic done_s;
   logic expire_s;
   logic stall_s;

   assign busy_s     = (state_q == ST_BUSY);
   assign done_s     = (state_q == ST_DONE);
   // DONE drains into a new accept in the same cycle MEM takes the result.
   assign ex_ready   = !flush && ((state_q == ST_IDLE) || (done_s && mem_ready));
   assign accept_s   = id_valid && ex_ready;
   // A completion arriving on the last allowed cycle beats the timeout.
   assign expire_s   = busy_s && !alu_done && (timer_q == TIMER_LAST);
   assign alu_start  = accept_s && multi_cycle;
   assign alu_cancel = busy_s && (flush || expire_s);
   assign ex_valid   = done_s;
   assign stall_s    = done_s && !mem_ready && (stall_q != STALL_MAX);
   assign timeout_err = err_q;
   assign stall_cnt   = stall_q;

   // Stage state, result register, timeout timer, sticky error and stall counter.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         timer_q  <= '0;
         err_q    <= 1'b0;
         stall_q  <= '0;
         result_q <= '0;
      end else begin
         if (stall_s) begin
            stall_q <= stall_q + STALL_ONE;
         end else begin
            stall_q <= stall_q;
         end

         if (flush) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
         end else begin
            case (state_q)
               ST_BUSY: begin
                  if (alu_done) begin
                     result_q <= alu_result;
                     state_q  <= ST_DONE;
                     timer_q  <= '0;
                  end else if (expire_s) begin
                     result_q <= '0;
                     err_q    <= 1'b1;
                     state_q  <= ST_DONE;
                     timer_q  <= '0;
                  end else begin
                     timer_q  <= timer_q + TIMER_ONE;
                  end
               end
               ST_IDLE, ST_DONE: begin
                  if (accept_s) begin
                     if (multi_cycle) begin
                        state_q <= ST_BUSY;
                        timer_q <= '0;
                     end else begin
                        result_q <= alu_result;
                        state_q  <= ST_DONE;
                     end
                  end else if (done_s && mem_ready) begin
                     state_q <= ST_IDLE;
                  end else begin
                     state_q <= state_q;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  timer_q <= '0;
               end
            endcase
         end
      end
   end

endmodule
